aoi21_pipe: RTL and testbench



---
 rtl/aoi21_pipe_if.sv | 41 ++++
 rtl/aoi21_pipe.sv | 128 ++++++++++++
 tb/tb_aoi21_pipe.sv | 476 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aoi21_pipe_if.sv
// Valid/ready stream bundle for aoi21_pipe: operand side (IN_*, A/B/C/MODE) and result side
// (OUT_*, Y). The producer/consumer environment uses master; the pipeline uses slave.
`timescale 1ns / 1ps

interface aoi21_pipe_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             IN_VALID;
    logic             IN_READY;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] C;
    logic [1:0]       MODE;
    logic             OUT_VALID;
    logic             OUT_READY;
    logic [WIDTH-1:0] Y;

    modport master (
        output IN_VALID,
        output A,
        output B,
        output C,
        output MODE,
        output OUT_READY,
        input  IN_READY,
        input  OUT_VALID,
        input  Y
    );

    modport slave (
        input  IN_VALID,
        input  A,
        input  B,
        input  C,
        input  MODE,
        input  OUT_READY,
        output IN_READY,
        output OUT_VALID,
        output Y
    );
endinterface

// File: rtl/aoi21_pipe.sv
// Pipelined WIDTH-lane AOI21/OAI21/AO21/OA21 datapath with DEPTH elastic valid/ready stages.
// Optional output toggle counter is built only when AOI_TOGGLE_CNT_EN is defined.
`timescale 1ns / 1ps

module aoi21_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned CNT_W = 16
) (
    input  logic             CLK,
    input  logic             R,
    aoi21_pipe_if.slave      bus,
    input  logic             TGL_CLR,
    output logic [CNT_W-1:0] TOGGLE_CNT
);

    logic [WIDTH-1:0] f_d;
    logic [DEPTH-1:0] v_q;
    logic [WIDTH-1:0] d_q [DEPTH];
    logic [DEPTH-1:0] rdy;

    // Mode is consumed together with the operands, so it travels inside the data word.
    always_comb begin
        f_d = '0;
        unique case (bus.MODE)
            2'b00:   f_d = ~((bus.A & bus.B) | bus.C);
            2'b01:   f_d = ~((bus.A | bus.B) & bus.C);
            2'b10:   f_d = (bus.A & bus.B) | bus.C;
            2'b11:   f_d = (bus.A | bus.B) & bus.C;
            default: f_d = '0;
        endcase
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic             v_in;
        logic [WIDTH-1:0] d_in;
        logic             v_d;
        logic [WIDTH-1:0] d_d;

        if (i == 0) begin : g_head
            assign v_in = bus.IN_VALID;
            assign d_in = f_d;
        end else begin : g_body
            assign v_in = v_q[i-1];
            assign d_in = d_q[i-1];
        end

        // Closed form of the ready chain: stage i can move unless it and every later stage are full
        // and the sink stalls.
        assign rdy[i] = bus.OUT_READY | ~(&v_q[DEPTH-1:i]);

        always_comb begin
            v_d = v_q[i];
            d_d = d_q[i];
            if (rdy[i]) begin
                v_d = v_in;
                if (v_in) begin
                    d_d = d_in;
                end
            end
        end

        always_ff @(posedge CLK or negedge R) begin
            if (!R) begin
                v_q[i] <= 1'b0;
                d_q[i] <= '0;
            end else begin
                v_q[i] <= v_d;
                d_q[i] <= d_d;
            end
        end
    end

    assign bus.IN_READY  = rdy[0];
    assign bus.OUT_VALID = v_q[DEPTH-1];
    assign bus.Y         = d_q[DEPTH-1];

`ifdef AOI_TOGGLE_CNT_EN
    localparam int unsigned SumW = CNT_W + 32;

    logic             hs;
    logic [WIDTH-1:0] last_y_q;
    logic [WIDTH-1:0] last_y_d;
    logic [CNT_W-1:0] tgl_cnt_q;
    logic [CNT_W-1:0] tgl_cnt_d;
    logic [WIDTH-1:0] diff;
    int unsigned      pop;
    logic [SumW-1:0]  sum;

    assign hs = bus.OUT_VALID & bus.OUT_READY;

    always_comb begin
        diff = bus.Y ^ last_y_q;
        pop  = 0;
        for (int k = 0; k < WIDTH; k++) begin
            pop = pop + 32'(diff[k]);
        end
        // Extra headroom so a wide popcount cannot wrap before the saturation test.
        sum       = SumW'(tgl_cnt_q) + SumW'(pop);
        tgl_cnt_d = tgl_cnt_q;
        last_y_d  = last_y_q;
        if (TGL_CLR) begin
            tgl_cnt_d = '0;
            last_y_d  = '0;
        end else if (hs) begin
            last_y_d  = bus.Y;
            tgl_cnt_d = (|sum[SumW-1:CNT_W]) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
        end
    end

    always_ff @(posedge CLK or negedge R) begin
        if (!R) begin
            tgl_cnt_q <= '0;
            last_y_q  <= '0;
        end else begin
            tgl_cnt_q <= tgl_cnt_d;
            last_y_q  <= last_y_d;
        end
    end

    assign TOGGLE_CNT = tgl_cnt_q;
`else
    logic unused_tgl_clr;
    assign unused_tgl_clr = TGL_CLR;
    assign TOGGLE_CNT     = '0;
`endif

endmodule

// File: tb/tb_aoi21_pipe.sv
// Directed self-checking bench for aoi21_pipe (WIDTH=8, DEPTH=2); a second CNT_W=4 instance
// mirrors the same stream to exercise counter saturation.
`timescale 1ns / 1ps

module tb_aoi21_pipe;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 16;

    logic             CLK = 1'b0;
    logic             R = 1'b0;
    logic             TGL_CLR = 1'b0;
    logic [CNT_W-1:0] toggle_cnt;
    logic [3:0]       toggle_cnt4;
    int               checks = 0;
    int               errors = 0;

    aoi21_pipe_if #(.WIDTH(WIDTH)) bus ();
    aoi21_pipe_if #(.WIDTH(WIDTH)) bus4 ();

    assign bus4.IN_VALID  = bus.IN_VALID;
    assign bus4.A         = bus.A;
    assign bus4.B         = bus.B;
    assign bus4.C         = bus.C;
    assign bus4.MODE      = bus.MODE;
    assign bus4.OUT_READY = bus.OUT_READY;

    aoi21_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .CLK        (CLK),
        .R          (R),
        .bus        (bus),
        .TGL_CLR    (TGL_CLR),
        .TOGGLE_CNT (toggle_cnt)
    );

    aoi21_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(4)) dut4 (
        .CLK        (CLK),
        .R          (R),
        .bus        (bus4),
        .TGL_CLR    (TGL_CLR),
        .TOGGLE_CNT (toggle_cnt4)
    );

    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic test_reset();
        bus.IN_VALID  = 1'b0;
        bus.A         = '0;
        bus.B         = '0;
        bus.C         = '0;
        bus.MODE      = 2'b00;
        bus.OUT_READY = 1'b1;
        #12;
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid: got %b want 0", bus.OUT_VALID);
        end
        checks++;
        if (bus.Y !== 8'h00) begin
            errors++;
            $display("FAIL reset_y: got %h want 00", bus.Y);
        end
        checks++;
        if (toggle_cnt !== '0) begin
            errors++;
            $display("FAIL reset_toggle_cnt: got %0d want 0", toggle_cnt);
        end
        @(negedge CLK);
        R = 1'b1;
        #1;
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready: got %b want 1", bus.IN_READY);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_stream();
        bus.MODE      = 2'b00;
        bus.A         = 8'hF0;
        bus.B         = 8'hCC;
        bus.C         = 8'h0A;
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        @(posedge CLK);
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL stream_latency: out_valid got %b want 0 after accept edge", bus.OUT_VALID);
        end
        for (int n = 0; n < 4; n++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (bus.OUT_VALID !== 1'b1 || bus.Y !== 8'h35) begin
                errors++;
                $display("FAIL stream_beat%0d: got v=%b y=%h want v=1 y=35", n, bus.OUT_VALID, bus.Y);
            end
        end
        bus.IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.Y !== 8'h35) begin
            errors++;
            $display("FAIL stream_tail: got v=%b y=%h want v=1 y=35", bus.OUT_VALID, bus.Y);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL stream_drain: out_valid got %b want 0", bus.OUT_VALID);
        end
    endtask

    task automatic test_mode_sweep();
        logic [7:0] expv [4];
        int         got;
        expv = '{8'hC1, 8'hD3, 8'h3E, 8'h2C};
        got  = 0;
        bus.A         = 8'hAA;
        bus.B         = 8'h0F;
        bus.C         = 8'h3C;
        bus.OUT_READY = 1'b1;
        for (int cyc = 0; cyc < 8; cyc++) begin
            if (cyc < 4) begin
                bus.IN_VALID = 1'b1;
                bus.MODE     = 2'(cyc);
            end else begin
                bus.IN_VALID = 1'b0;
                bus.MODE     = 2'b00;
            end
            @(posedge CLK);
            #1;
            if (bus.OUT_VALID === 1'b1) begin
                checks++;
                if (got >= 4) begin
                    errors++;
                    $display("FAIL mode_extra_beat: got y=%h want no beat", bus.Y);
                end else if (bus.Y !== expv[got]) begin
                    errors++;
                    $display("FAIL mode_beat%0d: got %h want %h", got, bus.Y, expv[got]);
                end
                got++;
            end
        end
        checks++;
        if (got !== 4) begin
            errors++;
            $display("FAIL mode_count: got %0d beats want 4", got);
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] expv [3];
        int         got;
        int         sent;
        logic       accept;
        expv = '{8'h11, 8'h22, 8'h33};
        bus.MODE      = 2'b10;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.OUT_READY = 1'b0;
        bus.IN_VALID  = 1'b1;
        bus.C         = 8'h11;
        #1;
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL bp_ready_empty: got %b want 1", bus.IN_READY);
        end
        @(posedge CLK);
        #1;
        bus.C = 8'h22;
        checks++;
        if (bus.IN_READY !== 1'b1 || bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL bp_one_beat: got rdy=%b v=%b want rdy=1 v=0", bus.IN_READY, bus.OUT_VALID);
        end
        @(posedge CLK);
        #1;
        bus.C = 8'h33;
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (bus.IN_READY !== 1'b0 || bus.OUT_VALID !== 1'b1 || bus.Y !== 8'h11) begin
                errors++;
                $display("FAIL bp_hold%0d: got rdy=%b v=%b y=%h want rdy=0 v=1 y=11",
                         n, bus.IN_READY, bus.OUT_VALID, bus.Y);
            end
            if (n < 3) begin
                @(posedge CLK);
                #1;
            end
        end
        bus.OUT_READY = 1'b1;
        #1;
        checks++;
        if (bus.IN_READY !== 1'b1) begin
            errors++;
            $display("FAIL bp_release_ready: got %b want 1", bus.IN_READY);
        end
        got  = 0;
        sent = 2;
        for (int cyc = 0; cyc < 8 && got < 3; cyc++) begin
            if (bus.OUT_VALID === 1'b1) begin
                checks++;
                if (got >= 3 || bus.Y !== expv[got]) begin
                    errors++;
                    $display("FAIL bp_out%0d: got %h want %h", got, bus.Y, expv[got]);
                end
                got++;
            end
            accept = bus.IN_VALID & bus.IN_READY;
            @(posedge CLK);
            #1;
            if (accept) begin
                sent++;
                bus.IN_VALID = 1'b0;
            end
        end
        checks++;
        if (got !== 3 || sent !== 3) begin
            errors++;
            $display("FAIL bp_count: got %0d out / %0d in want 3 / 3", got, sent);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL bp_no_dup: out_valid got %b want 0", bus.OUT_VALID);
        end
    endtask

    task automatic test_bubbles();
        bus.MODE      = 2'b10;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        bus.C         = 8'h5A;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        bus.C        = 8'hFF;
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL bubble_e1: got v=%b want 0", bus.OUT_VALID);
        end
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b1;
        bus.C        = 8'hA5;
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.Y !== 8'h5A) begin
            errors++;
            $display("FAIL bubble_e2: got v=%b y=%h want v=1 y=5a", bus.OUT_VALID, bus.Y);
        end
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.Y !== 8'h5A) begin
            errors++;
            $display("FAIL bubble_e3: got v=%b y=%h want v=0 y=5a", bus.OUT_VALID, bus.Y);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.Y !== 8'hA5) begin
            errors++;
            $display("FAIL bubble_e4: got v=%b y=%h want v=1 y=a5", bus.OUT_VALID, bus.Y);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_async_reset();
        bus.MODE      = 2'b10;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.C         = 8'h77;
        bus.OUT_READY = 1'b1;
        bus.IN_VALID  = 1'b1;
        @(posedge CLK);
        #1;
        @(posedge CLK);
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.Y !== 8'h77) begin
            errors++;
            $display("FAIL arst_pre: got v=%b y=%h want v=1 y=77", bus.OUT_VALID, bus.Y);
        end
        #2;
        R = 1'b0;
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b0 || bus.Y !== 8'h00) begin
            errors++;
            $display("FAIL arst_immediate: got v=%b y=%h want v=0 y=00", bus.OUT_VALID, bus.Y);
        end
        checks++;
        if (toggle_cnt !== '0) begin
            errors++;
            $display("FAIL arst_toggle_cnt: got %0d want 0", toggle_cnt);
        end
        bus.IN_VALID = 1'b0;
        @(posedge CLK);
        #4;
        R = 1'b1;
        for (int n = 0; n < 2; n++) begin
            @(posedge CLK);
            #1;
            checks++;
            if (bus.OUT_VALID !== 1'b0) begin
                errors++;
                $display("FAIL arst_quiet%0d: got v=%b want 0", n, bus.OUT_VALID);
            end
        end
        bus.IN_VALID = 1'b1;
        bus.C        = 8'h12;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        checks++;
        if (bus.OUT_VALID !== 1'b0) begin
            errors++;
            $display("FAIL arst_new_lat: got v=%b want 0", bus.OUT_VALID);
        end
        @(posedge CLK);
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b1 || bus.Y !== 8'h12) begin
            errors++;
            $display("FAIL arst_new_beat: got v=%b y=%h want v=1 y=12", bus.OUT_VALID, bus.Y);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic test_toggle();
        logic [7:0] vals [3];
        bus.MODE      = 2'b10;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.OUT_READY = 1'b1;
`ifdef AOI_TOGGLE_CNT_EN
        TGL_CLR = 1'b1;
        @(posedge CLK);
        #1;
        TGL_CLR = 1'b0;
        checks++;
        if (toggle_cnt !== 16'd0 || toggle_cnt4 !== 4'd0) begin
            errors++;
            $display("FAIL tgl_clear0: got %0d/%0d want 0/0", toggle_cnt, toggle_cnt4);
        end
        vals = '{8'h00, 8'hFF, 8'h0F};
        for (int cyc = 0; cyc < 6; cyc++) begin
            bus.IN_VALID = (cyc < 3);
            bus.C        = (cyc < 3) ? vals[cyc] : 8'h00;
            @(posedge CLK);
            #1;
        end
        checks++;
        if (toggle_cnt !== 16'd12 || toggle_cnt4 !== 4'd12) begin
            errors++;
            $display("FAIL tgl_count12: got %0d/%0d want 12/12", toggle_cnt, toggle_cnt4);
        end
        TGL_CLR = 1'b1;
        @(posedge CLK);
        #1;
        TGL_CLR = 1'b0;
        checks++;
        if (toggle_cnt !== 16'd0) begin
            errors++;
            $display("FAIL tgl_clear: got %0d want 0", toggle_cnt);
        end
        bus.IN_VALID = 1'b1;
        bus.C        = 8'hFF;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        @(posedge CLK);
        #1;
        checks++;
        if (bus.OUT_VALID !== 1'b1) begin
            errors++;
            $display("FAIL tgl_prio_pre: got v=%b want 1", bus.OUT_VALID);
        end
        TGL_CLR = 1'b1;
        @(posedge CLK);
        #1;
        TGL_CLR = 1'b0;
        checks++;
        if (toggle_cnt !== 16'd0) begin
            errors++;
            $display("FAIL tgl_clear_priority: got %0d want 0", toggle_cnt);
        end
        bus.IN_VALID = 1'b1;
        bus.C        = 8'hFF;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        repeat (2) begin
            @(posedge CLK);
            #1;
        end
        checks++;
        if (toggle_cnt !== 16'd8) begin
            errors++;
            $display("FAIL tgl_last_y_cleared: got %0d want 8", toggle_cnt);
        end
        TGL_CLR = 1'b1;
        @(posedge CLK);
        #1;
        TGL_CLR = 1'b0;
        vals = '{8'hFF, 8'h00, 8'h0F};
        for (int cyc = 0; cyc < 6; cyc++) begin
            bus.IN_VALID = (cyc < 3);
            bus.C        = (cyc < 3) ? vals[cyc] : 8'h00;
            @(posedge CLK);
            #1;
        end
        checks++;
        if (toggle_cnt !== 16'd20) begin
            errors++;
            $display("FAIL tgl_count20: got %0d want 20", toggle_cnt);
        end
        checks++;
        if (toggle_cnt4 !== 4'd15) begin
            errors++;
            $display("FAIL tgl_saturate: got %0d want 15", toggle_cnt4);
        end
`else
        vals = '{8'hFF, 8'h00, 8'h0F};
        for (int cyc = 0; cyc < 6; cyc++) begin
            bus.IN_VALID = (cyc < 3);
            bus.C        = (cyc < 3) ? vals[cyc] : 8'h00;
            TGL_CLR      = (cyc == 4);
            @(posedge CLK);
            #1;
            checks++;
            if (toggle_cnt !== 16'd0 || toggle_cnt4 !== 4'd0) begin
                errors++;
                $display("FAIL tgl_disabled%0d: got %0d/%0d want 0/0", cyc, toggle_cnt, toggle_cnt4);
            end
        end
        TGL_CLR = 1'b0;
`endif
    endtask

    initial begin
        test_reset();
        test_stream();
        test_mode_sweep();
        test_backpressure();
        test_bubbles();
        test_async_reset();
        test_toggle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
